// File: rtl/usbf_csr_fifo_port.sv
// usbf_csr_fifo_port
//   CSR-side data port for one USB endpoint. Decodes BIU write/read strobes
//   into three word registers (DATA, STAT, CTRL), owns a CPU->core TX FIFO and
//   a core->CPU RX FIFO, and keeps sticky overflow/underflow flags.
// Ports
//   hclk_i, hrstn_i          : clock, synchronous active-low reset
//   wt_en_i/rd_en_i/enable_i : BIU strobes; write wins when both accepted
//   addr_i, wdata_i          : byte address ([11:0] decoded), write data
//   rdata_o                  : registered read data, held until next read
//   wt_ready_o, rd_ready_o   : one-cycle completion pulses
//   tx_pop_i, tx_data_o      : core pops TX; show-ahead head word
//   tx_empty_o               : TX FIFO empty
//   rx_push_i, rx_data_i     : core pushes RX
//   rx_full_o                : RX FIFO full
module usbf_csr_fifo_port #(
  parameter int unsigned AW       = 4,
  parameter logic [11:0] DATA_OFS = 12'h100,
  parameter logic [11:0] STAT_OFS = 12'h104,
  parameter logic [11:0] CTRL_OFS = 12'h108
) (
  input  logic        hclk_i,
  input  logic        hrstn_i,
  input  logic        wt_en_i,
  input  logic        rd_en_i,
  input  logic        enable_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        wt_ready_o,
  output logic        rd_ready_o,
  input  logic        tx_pop_i,
  output logic [31:0] tx_data_o,
  output logic        tx_empty_o,
  input  logic        rx_push_i,
  input  logic [31:0] rx_data_i,
  output logic        rx_full_o
);

  localparam int unsigned DEPTH    = 1 << AW;
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [31:0]   r_tx_mem [DEPTH];
  logic [31:0]   r_rx_mem [DEPTH];
  logic [AW-1:0] r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp;
  logic [AW:0]   r_tx_level, r_rx_level;
  logic          r_tx_ovf, r_rx_udf, r_rx_ovf;

  logic [11:0] w_off;
  logic        w_wr_acc, w_rd_acc;
  logic        w_data_wr, w_ctrl_wr, w_data_rd, w_stat_rd;
  logic        w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  logic        w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
  logic        w_tx_flush, w_rx_flush;
  logic        w_tx_ovf_set, w_rx_udf_set, w_rx_ovf_set;
  logic        w_tx_ovf_clr, w_rx_err_clr;
  logic [31:0] w_stat, w_rd_val;
  logic        w_unused_addr_hi;

  assign w_unused_addr_hi = &{1'b0, addr_i[31:12]};

  // Write has priority: a simultaneous read is dropped and never acknowledged.
  assign w_off     = addr_i[11:0];
  assign w_wr_acc  = wt_en_i & enable_i;
  assign w_rd_acc  = rd_en_i & enable_i & ~w_wr_acc;
  assign w_data_wr = w_wr_acc && (w_off == DATA_OFS);
  assign w_ctrl_wr = w_wr_acc && (w_off == CTRL_OFS);
  assign w_data_rd = w_rd_acc && (w_off == DATA_OFS);
  assign w_stat_rd = w_rd_acc && (w_off == STAT_OFS);

  assign w_tx_full  = (r_tx_level == FULL_LVL);
  assign w_tx_empty = (r_tx_level == '0);
  assign w_rx_full  = (r_rx_level == FULL_LVL);
  assign w_rx_empty = (r_rx_level == '0);

  assign w_tx_flush   = w_ctrl_wr & wdata_i[0];
  assign w_rx_flush   = w_ctrl_wr & wdata_i[1];
  assign w_tx_ovf_clr = w_ctrl_wr & wdata_i[2];
  assign w_rx_err_clr = w_ctrl_wr & wdata_i[3];

  assign w_tx_push = w_data_wr & ~w_tx_full;
  assign w_tx_pop  = tx_pop_i  & ~w_tx_empty;
  assign w_rx_push = rx_push_i & ~w_rx_full;
  assign w_rx_pop  = w_data_rd & ~w_rx_empty;

  // A flush on the same FIFO suppresses the error it would otherwise raise.
  assign w_tx_ovf_set = w_data_wr & w_tx_full & ~w_tx_flush;
  assign w_rx_udf_set = w_data_rd & w_rx_empty & ~w_rx_flush;
  assign w_rx_ovf_set = rx_push_i & w_rx_full & ~w_rx_flush;

  always_comb begin
    w_stat        = '0;
    w_stat[7:0]   = 8'(r_tx_level);
    w_stat[15:8]  = 8'(r_rx_level);
    w_stat[16]    = w_tx_full;
    w_stat[17]    = w_tx_empty;
    w_stat[18]    = w_rx_full;
    w_stat[19]    = w_rx_empty;
    w_stat[20]    = r_tx_ovf;
    w_stat[21]    = r_rx_udf;
    w_stat[22]    = r_rx_ovf;
  end

  always_comb begin
    w_rd_val = '0;
    if (w_data_rd && !w_rx_empty) w_rd_val = r_rx_mem[r_rx_rp];
    else if (w_stat_rd)           w_rd_val = w_stat;
  end

  // Storage arrays carry no reset; pointers/levels define validity.
  always_ff @(posedge hclk_i) begin
    if (w_tx_push) r_tx_mem[r_tx_wp] <= wdata_i;
    if (w_rx_push) r_rx_mem[r_rx_wp] <= rx_data_i;
  end

  always_ff @(posedge hclk_i) begin
    if (!hrstn_i) begin
      r_tx_wp    <= '0;
      r_tx_rp    <= '0;
      r_tx_level <= '0;
    end else if (w_tx_flush) begin
      r_tx_wp    <= '0;
      r_tx_rp    <= '0;
      r_tx_level <= '0;
    end else begin
      if (w_tx_push) r_tx_wp <= r_tx_wp + AW'(1);
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + AW'(1);
      if (w_tx_push && !w_tx_pop)      r_tx_level <= r_tx_level + (AW+1)'(1);
      else if (!w_tx_push && w_tx_pop) r_tx_level <= r_tx_level - (AW+1)'(1);
    end
  end

  always_ff @(posedge hclk_i) begin
    if (!hrstn_i) begin
      r_rx_wp    <= '0;
      r_rx_rp    <= '0;
      r_rx_level <= '0;
    end else if (w_rx_flush) begin
      r_rx_wp    <= '0;
      r_rx_rp    <= '0;
      r_rx_level <= '0;
    end else begin
      if (w_rx_push) r_rx_wp <= r_rx_wp + AW'(1);
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + AW'(1);
      if (w_rx_push && !w_rx_pop)      r_rx_level <= r_rx_level + (AW+1)'(1);
      else if (!w_rx_push && w_rx_pop) r_rx_level <= r_rx_level - (AW+1)'(1);
    end
  end

  // Sticky flags: a same-cycle set beats a CTRL clear.
  always_ff @(posedge hclk_i) begin
    if (!hrstn_i) begin
      r_tx_ovf <= 1'b0;
      r_rx_udf <= 1'b0;
      r_rx_ovf <= 1'b0;
    end else begin
      if (w_tx_ovf_set)      r_tx_ovf <= 1'b1;
      else if (w_tx_ovf_clr) r_tx_ovf <= 1'b0;
      if (w_rx_udf_set)      r_rx_udf <= 1'b1;
      else if (w_rx_err_clr) r_rx_udf <= 1'b0;
      if (w_rx_ovf_set)      r_rx_ovf <= 1'b1;
      else if (w_rx_err_clr) r_rx_ovf <= 1'b0;
    end
  end

  always_ff @(posedge hclk_i) begin
    if (!hrstn_i) begin
      rdata_o    <= '0;
      wt_ready_o <= 1'b0;
      rd_ready_o <= 1'b0;
    end else begin
      wt_ready_o <= w_wr_acc;
      rd_ready_o <= w_rd_acc;
      if (w_rd_acc) rdata_o <= w_rd_val;
    end
  end

  assign tx_empty_o = w_tx_empty;
  assign rx_full_o  = w_rx_full;
  assign tx_data_o  = w_tx_empty ? '0 : r_tx_mem[r_tx_rp];

endmodule

// File: tb/tb_usbf_csr_fifo_port.sv
// Self-checking bench for usbf_csr_fifo_port: a vector table for single-cycle
// behaviour plus hand sequences for fill/drain, flush, flag and reset cases.
// Read data is checked through a queue of expected words consumed on rd_ready_o.
module tb_usbf_csr_fifo_port;

  localparam logic [11:0] DATA = 12'h100;
  localparam logic [11:0] STAT = 12'h104;
  localparam logic [11:0] CTRL = 12'h108;
  localparam logic Y = 1'b1;
  localparam logic N = 1'b0;

  logic        clk = 1'b0;
  logic        rstn;
  logic        wt_en, rd_en, enable;
  logic [31:0] addr, wdata, rdata;
  logic        wt_ready, rd_ready;
  logic        tx_pop, tx_empty, rx_push, rx_full;
  logic [31:0] tx_data, rx_data;

  usbf_csr_fifo_port #(.AW(4)) dut (
    .hclk_i     (clk),
    .hrstn_i    (rstn),
    .wt_en_i    (wt_en),
    .rd_en_i    (rd_en),
    .enable_i   (enable),
    .addr_i     (addr),
    .wdata_i    (wdata),
    .rdata_o    (rdata),
    .wt_ready_o (wt_ready),
    .rd_ready_o (rd_ready),
    .tx_pop_i   (tx_pop),
    .tx_data_o  (tx_data),
    .tx_empty_o (tx_empty),
    .rx_push_i  (rx_push),
    .rx_data_i  (rx_data),
    .rx_full_o  (rx_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  typedef struct {
    logic        wt, rd, en;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        txp, rxp;
    logic [31:0] rxd;
    logic [31:0] exp_rd;
    logic        exp_te;
    logic [31:0] exp_td;
  } vec_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_wt_seen = 0;
  int   exp_wt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (wt_ready) n_wt_seen++;
    if (rd_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL rd_unexpected: got rd_ready with rdata %h expected no pulse", rdata);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk(e.name, rdata, e.val);
      end
    end
  end

  task automatic clear_strobes();
    wt_en = 1'b0; rd_en = 1'b0; enable = 1'b0;
    tx_pop = 1'b0; rx_push = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [11:0] a, input logic [31:0] d);
    wt_en = 1'b1; enable = 1'b1; addr = {20'h0, a}; wdata = d;
    exp_wt++;
    tick();
    clear_strobes();
  endtask

  task automatic bus_rd(input logic [11:0] a, input logic [31:0] e, input string nm);
    exp_t x;
    rd_en = 1'b1; enable = 1'b1; addr = {20'h0, a};
    x.name = nm; x.val = e;
    exp_q.push_back(x);
    tick();
    clear_strobes();
  endtask

  task automatic core_op(input logic pop, input logic push, input logic [31:0] d);
    tx_pop = pop; rx_push = push; rx_data = d;
    tick();
    clear_strobes();
  endtask

  task automatic sync_chk(input string nm);
    tick();
    tick();
    chk({nm, "_wt_cnt"}, 32'(n_wt_seen), 32'(exp_wt));
    chk({nm, "_rd_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    clear_strobes();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  vec_t tbl[22];

  initial begin
    addr = '0; wdata = '0; rx_data = '0;
    clear_strobes();
    do_reset();

    chk("rst_tx_empty", {31'd0, tx_empty}, 32'd1);
    chk("rst_rx_full",  {31'd0, rx_full},  32'd0);
    chk("rst_tx_data",  tx_data, 32'd0);
    chk("rst_rdata",    rdata, 32'd0);
    chk("rst_wt_ready", {31'd0, wt_ready}, 32'd0);
    chk("rst_rd_ready", {31'd0, rd_ready}, 32'd0);

    //          wt rd en addr  wdata        txp rxp rxd           exp_rd        te  td
    tbl[0]  = '{Y, N, N, DATA, 32'h11,      N,  N,  32'h0,        32'h0,        Y,  32'h0};
    tbl[1]  = '{N, Y, N, DATA, 32'h0,       N,  N,  32'h0,        32'h0,        Y,  32'h0};
    tbl[2]  = '{Y, N, Y, DATA, 32'h22,      N,  N,  32'h0,        32'h0,        N,  32'h22};
    tbl[3]  = '{Y, N, Y, DATA, 32'h33,      N,  N,  32'h0,        32'h0,        N,  32'h22};
    tbl[4]  = '{N, N, N, DATA, 32'h0,       N,  Y,  32'hA5A50001, 32'h0,        N,  32'h22};
    tbl[5]  = '{N, N, N, DATA, 32'h0,       N,  Y,  32'hA5A50002, 32'h0,        N,  32'h22};
    tbl[6]  = '{N, Y, Y, DATA, 32'h0,       N,  N,  32'h0,        32'hA5A50001, N,  32'h22};
    tbl[7]  = '{N, Y, Y, DATA, 32'h0,       N,  N,  32'h0,        32'hA5A50002, N,  32'h22};
    tbl[8]  = '{N, Y, Y, DATA, 32'h0,       N,  N,  32'h0,        32'h0,        N,  32'h22};
    tbl[9]  = '{N, Y, Y, STAT, 32'h0,       N,  N,  32'h0,        32'h0028_0002, N, 32'h22};
    tbl[10] = '{Y, Y, Y, DATA, 32'h44,      N,  N,  32'h0,        32'h0,        N,  32'h22};
    tbl[11] = '{N, N, N, DATA, 32'h0,       Y,  N,  32'h0,        32'h0,        N,  32'h33};
    tbl[12] = '{N, Y, Y, CTRL, 32'h0,       Y,  N,  32'h0,        32'h0,        N,  32'h44};
    tbl[13] = '{Y, N, Y, 12'h10C, 32'hFFFF, N,  N,  32'h0,        32'h0,        N,  32'h44};
    tbl[14] = '{N, Y, Y, 12'h200, 32'h0,    N,  N,  32'h0,        32'h0,        N,  32'h44};
    tbl[15] = '{Y, N, Y, CTRL, 32'h4,       N,  N,  32'h0,        32'h0,        N,  32'h44};
    tbl[16] = '{N, Y, Y, STAT, 32'h0,       N,  N,  32'h0,        32'h0028_0001, N, 32'h44};
    tbl[17] = '{Y, N, Y, CTRL, 32'h8,       N,  N,  32'h0,        32'h0,        N,  32'h44};
    tbl[18] = '{N, Y, Y, STAT, 32'h0,       N,  N,  32'h0,        32'h0008_0001, N, 32'h44};
    tbl[19] = '{N, N, N, DATA, 32'h0,       Y,  N,  32'h0,        32'h0,        Y,  32'h0};
    tbl[20] = '{N, N, N, DATA, 32'h0,       Y,  N,  32'h0,        32'h0,        Y,  32'h0};
    tbl[21] = '{N, Y, Y, STAT, 32'h0,       N,  N,  32'h0,        32'h000A_0000, Y, 32'h0};

    for (int i = 0; i < 22; i++) begin
      wt_en = tbl[i].wt; rd_en = tbl[i].rd; enable = tbl[i].en;
      addr = {20'h0, tbl[i].addr}; wdata = tbl[i].wdata;
      tx_pop = tbl[i].txp; rx_push = tbl[i].rxp; rx_data = tbl[i].rxd;
      if (tbl[i].wt && tbl[i].en) exp_wt++;
      else if (tbl[i].rd && tbl[i].en) begin
        exp_t x;
        x.name = $sformatf("vec%0d_rdata", i);
        x.val  = tbl[i].exp_rd;
        exp_q.push_back(x);
      end
      tick();
      clear_strobes();
      chk($sformatf("vec%0d_tx_empty", i), {31'd0, tx_empty}, {31'd0, tbl[i].exp_te});
      chk($sformatf("vec%0d_tx_data", i), tx_data, tbl[i].exp_td);
    end
    sync_chk("table");

    // TX fill to full, overflow, then drain in order.
    do_reset();
    for (int i = 0; i < 16; i++) bus_wr(DATA, 32'h1000 + 32'(i));
    chk("fill_tx_empty", {31'd0, tx_empty}, 32'd0);
    bus_rd(STAT, 32'h0009_0010, "fill_stat");
    bus_wr(DATA, 32'hDEAD);
    bus_rd(STAT, 32'h0019_0010, "ovf_stat");
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain%0d_tx_data", i), tx_data, 32'h1000 + 32'(i));
      core_op(1'b1, 1'b0, 32'h0);
    end
    chk("drain_tx_empty", {31'd0, tx_empty}, 32'd1);
    sync_chk("fill");

    // Simultaneous CPU push and core pop at level 3.
    bus_wr(CTRL, 32'h4);
    bus_rd(STAT, 32'h000A_0000, "clr_stat");
    for (int i = 0; i < 3; i++) bus_wr(DATA, 32'h2000 + 32'(i));
    chk("simul_head_before", tx_data, 32'h2000);
    tx_pop = 1'b1;
    bus_wr(DATA, 32'h2003);
    chk("simul_head_after", tx_data, 32'h2001);
    bus_rd(STAT, 32'h0008_0003, "simul_stat");

    // Flush overrides a same-cycle pop at level 5.
    bus_wr(DATA, 32'h2004);
    bus_wr(DATA, 32'h2005);
    bus_rd(STAT, 32'h0008_0005, "pre_flush_stat");
    tx_pop = 1'b1;
    bus_wr(CTRL, 32'h1);
    chk("flush_tx_empty", {31'd0, tx_empty}, 32'd1);
    chk("flush_tx_data", tx_data, 32'h0);
    bus_rd(STAT, 32'h000A_0000, "flush_stat");
    sync_chk("flush");

    // RX full: overflow set wins over a same-cycle clear, later clear works.
    for (int i = 0; i < 16; i++) core_op(1'b0, 1'b1, 32'hB000 + 32'(i));
    chk("rx_full_flag", {31'd0, rx_full}, 32'd1);
    bus_rd(STAT, 32'h0006_1000, "rxfull_stat");
    rx_push = 1'b1; rx_data = 32'hBAD;
    bus_wr(CTRL, 32'h8);
    bus_rd(STAT, 32'h0046_1000, "ovf_wins_stat");
    bus_wr(CTRL, 32'h8);
    bus_rd(STAT, 32'h0006_1000, "ovf_clr_stat");
    bus_rd(DATA, 32'hB000, "rx_head");
    bus_wr(CTRL, 32'h2);
    chk("rx_flush_full", {31'd0, rx_full}, 32'd0);
    bus_rd(STAT, 32'h000A_0000, "rx_flush_stat");
    sync_chk("rxflag");

    // Reset mid-operation with level 7; the write accepted at the reset edge is dropped.
    for (int i = 0; i < 7; i++) bus_wr(DATA, 32'h3000 + 32'(i));
    bus_rd(STAT, 32'h0008_0007, "pre_rst_stat");
    rstn = 1'b0; wt_en = 1'b1; enable = 1'b1; addr = {20'h0, DATA}; wdata = 32'h3FFF;
    tick();
    clear_strobes();
    rstn = 1'b1;
    chk("mid_rst_tx_empty", {31'd0, tx_empty}, 32'd1);
    chk("mid_rst_rx_full",  {31'd0, rx_full},  32'd0);
    chk("mid_rst_tx_data",  tx_data, 32'h0);
    chk("mid_rst_rdata",    rdata, 32'h0);
    chk("mid_rst_wt_ready", {31'd0, wt_ready}, 32'd0);
    chk("mid_rst_rd_ready", {31'd0, rd_ready}, 32'd0);
    bus_rd(STAT, 32'h000A_0000, "post_rst_stat");
    sync_chk("reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
